// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: shared state encoding and multi-cycle opcode decode for the FPU op sequencer
package fpu_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  localparam logic [4:0] MC_OP0 = 5'b00010;
  localparam logic [4:0] MC_OP1 = 5'b00011;
  localparam logic [4:0] MC_OP2 = 5'b01011;
  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == MC_OP0) || (op == MC_OP1) || (op == MC_OP2);
  endfunction
endpackage

// File: rtl/fpu_op_sequencer_if.sv
// fpu_op_sequencer_if: core request, multi-cycle unit and result signals of the FPU op sequencer
interface fpu_op_sequencer_if;
  logic       req_valid;
  logic [4:0] req_op;
  logic       req_ready;
  logic       flush;
  logic       mc_done;
  logic       mc_start;
  logic       in_sel;
  logic       reg_AB_en;
  logic       stall;
  logic       res_valid;
  logic       res_is_mc;
  logic       timeout;
  modport master (
    output req_valid, req_op, flush, mc_done,
    input  req_ready, mc_start, in_sel, reg_AB_en, stall, res_valid, res_is_mc, timeout
  );
  modport slave (
    input  req_valid, req_op, flush, mc_done,
    output req_ready, mc_start, in_sel, reg_AB_en, stall, res_valid, res_is_mc, timeout
  );
endinterface

// File: rtl/fpu_watchdog_cnt.sv
// fpu_watchdog_cnt: 8-bit saturating wait counter with a hit flag at the timeout limit
module fpu_watchdog_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic hit
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  // clear wins over counting; counting stops at 8'hff instead of wrapping
  always_comb begin
    cnt_d = clear ? 8'd0 : (en && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
  end
  // counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
  assign hit = cnt_q == LIMIT;
endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issues single-cycle FPU ops back-to-back and sequences div/sqrt through a watchdog-guarded multi-cycle unit
module fpu_op_sequencer
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input logic                 clk,
  input logic                 reset,
  fpu_op_sequencer_if.slave   bus
);
  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       res_valid_q, res_valid_d;
  logic       res_is_mc_q, res_is_mc_d;
  logic       idle, accept, req_mc, wd_hit;
  assign idle   = state_q == IDLE;
  assign accept = idle & bus.req_valid & ~bus.flush;
  assign req_mc = is_multicycle(bus.req_op);
  // next state, latched op and result pulses; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && req_mc) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (bus.mc_done) state_d = DONE; else if (wd_hit) state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
    op_d        = (accept && req_mc) ? bus.req_op : op_q;
    res_valid_d = (accept && !req_mc) || state_d == DONE;
    res_is_mc_d = state_d == DONE && is_multicycle(op_q);
  end
  // FSM and registered result flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 5'd0;
      res_valid_q <= 1'b0;
      res_is_mc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_is_mc_q <= res_is_mc_d;
    end
  end
  fpu_watchdog_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == LAUNCH),
    .en    (state_q == WAIT),
    .hit   (wd_hit)
  );
  assign bus.req_ready = idle & ~bus.flush;
  assign bus.in_sel    = idle;
  assign bus.reg_AB_en = idle;
  assign bus.stall     = state_q == LAUNCH || state_q == WAIT;
  assign bus.mc_start  = state_q == LAUNCH && !bus.flush;
  assign bus.res_valid = res_valid_q & ~bus.flush;
  assign bus.res_is_mc = res_is_mc_q;
  assign bus.timeout   = state_q == WAIT && wd_hit && !bus.mc_done && !bus.flush;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed scenarios with a result scoreboard for the FPU op sequencer
module tb_fpu_op_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int fails = 0;
  int total = 0;
  int mc_start_cnt = 0;
  int stall_cnt = 0;
  int sb[$];
  fpu_op_sequencer_if bus();
  fpu_op_sequencer #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask
  // result monitor: kind 0 = single-cycle result, 1 = multi-cycle result, 2 = timeout
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mc_start) mc_start_cnt++;
      if (bus.res_valid || bus.timeout) begin
        if (sb.size() == 0) check("sb_unexpected_event", sb.size(), 1);
        else check("sb_kind", bus.res_valid ? (bus.res_is_mc ? 1 : 0) : 2, sb.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 5'd0;
    bus.flush = 1'b0;
    bus.mc_done = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_in_sel", bus.in_sel, 1);
    check("rst_reg_AB_en", bus.reg_AB_en, 1);
    check("rst_stall", bus.stall, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_mc_start", bus.mc_start, 0);
    check("rst_timeout", bus.timeout, 0);
    next_cycle;
    next_cycle;
    reset = 1'b0;
    // three back-to-back single-cycle ops
    for (int i = 0; i < 3; i++) begin
      next_cycle;
      bus.req_valid = 1'b1;
      bus.req_op = 5'b00000;
      #1;
      check("sc_req_ready", bus.req_ready, 1);
      check("sc_stall", bus.stall, 0);
      if (i > 0) check("sc_res_valid_b2b", bus.res_valid, 1);
      sb.push_back(0);
    end
    next_cycle;
    bus.req_valid = 1'b0;
    #1;
    check("sc_res_valid_last", bus.res_valid, 1);
    check("sc_res_is_mc", bus.res_is_mc, 0);
    check("sc_stall_last", bus.stall, 0);
    next_cycle;
    #1;
    check("sc_res_valid_idle", bus.res_valid, 0);
    // multi-cycle op, mc_done on the fifth WAIT cycle (coincides with the watchdog hit)
    next_cycle;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b00011;
    #1;
    check("mc_req_ready", bus.req_ready, 1);
    sb.push_back(1);
    mc_start_cnt = 0;
    stall_cnt = 0;
    next_cycle;
    bus.req_valid = 1'b0;
    #1;
    check("mc_launch_start", bus.mc_start, 1);
    check("mc_launch_in_sel", bus.in_sel, 0);
    check("mc_launch_reg_en", bus.reg_AB_en, 0);
    check("mc_launch_ready", bus.req_ready, 0);
    stall_cnt += int'(bus.stall);
    for (int w = 1; w <= 5; w++) begin
      next_cycle;
      bus.mc_done = (w == 5);
      #1;
      stall_cnt += int'(bus.stall);
      check("mc_wait_start", bus.mc_start, 0);
      check("mc_wait_timeout", bus.timeout, 0);
    end
    next_cycle;
    bus.mc_done = 1'b0;
    #1;
    check("mc_done_res_valid", bus.res_valid, 1);
    check("mc_done_res_is_mc", bus.res_is_mc, 1);
    check("mc_done_stall", bus.stall, 0);
    check("mc_done_ready", bus.req_ready, 0);
    check("mc_stall_cycles", stall_cnt, 6);
    check("mc_start_pulses", mc_start_cnt, 1);
    next_cycle;
    #1;
    check("mc_back_idle_ready", bus.req_ready, 1);
    check("mc_back_idle_res", bus.res_valid, 0);
    // watchdog timeout with mc_done never asserted
    next_cycle;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b00010;
    #1;
    sb.push_back(2);
    next_cycle;
    bus.req_valid = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      next_cycle;
      #1;
      check("to_timeout", bus.timeout, w == 5);
      check("to_res_valid", bus.res_valid, 0);
    end
    next_cycle;
    #1;
    check("to_idle_ready", bus.req_ready, 1);
    check("to_pulse_once", bus.timeout, 0);
    check("to_no_res", bus.res_valid, 0);
    // mc_done ignored in LAUNCH, then flush with mc_done in WAIT
    next_cycle;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b01011;
    next_cycle;
    bus.req_valid = 1'b0;
    bus.mc_done = 1'b1;
    #1;
    check("fl_launch_start", bus.mc_start, 1);
    next_cycle;
    bus.mc_done = 1'b0;
    #1;
    check("fl_launch_done_ignored_stall", bus.stall, 1);
    check("fl_launch_done_ignored_res", bus.res_valid, 0);
    next_cycle;
    bus.flush = 1'b1;
    bus.mc_done = 1'b1;
    #1;
    check("fl_wait_res", bus.res_valid, 0);
    check("fl_wait_timeout", bus.timeout, 0);
    next_cycle;
    bus.flush = 1'b0;
    bus.mc_done = 1'b0;
    #1;
    check("fl_idle_ready", bus.req_ready, 1);
    check("fl_idle_stall", bus.stall, 0);
    check("fl_idle_res", bus.res_valid, 0);
    // flush in IDLE blocks acceptance
    next_cycle;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b00000;
    bus.flush = 1'b1;
    #1;
    check("fl_idle_block_ready", bus.req_ready, 0);
    next_cycle;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("fl_idle_block_res", bus.res_valid, 0);
    // reset mid-WAIT, then a fresh multi-cycle op
    next_cycle;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b00011;
    next_cycle;
    bus.req_valid = 1'b0;
    next_cycle;
    next_cycle;
    #1;
    check("rw_in_wait_stall", bus.stall, 1);
    reset = 1'b1;
    #1;
    check("rw_async_stall", bus.stall, 0);
    check("rw_async_ready", bus.req_ready, 1);
    check("rw_async_in_sel", bus.in_sel, 1);
    check("rw_async_reg_en", bus.reg_AB_en, 1);
    check("rw_async_timeout", bus.timeout, 0);
    check("rw_async_start", bus.mc_start, 0);
    next_cycle;
    reset = 1'b0;
    next_cycle;
    bus.req_valid = 1'b1;
    bus.req_op = 5'b01011;
    #1;
    check("rw_new_ready", bus.req_ready, 1);
    sb.push_back(1);
    next_cycle;
    bus.req_valid = 1'b0;
    #1;
    check("rw_new_launch", bus.mc_start, 1);
    next_cycle;
    bus.mc_done = 1'b1;
    #1;
    check("rw_new_wait_stall", bus.stall, 1);
    next_cycle;
    bus.mc_done = 1'b0;
    #1;
    check("rw_new_res_valid", bus.res_valid, 1);
    check("rw_new_res_is_mc", bus.res_is_mc, 1);
    next_cycle;
    next_cycle;
    #1;
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
